// File: rtl/matmul_seq_ctrl_if.sv
// Host-side streaming port of the matrix-multiply sequencer.
// Operand beats flow in on in_*, result elements flow out on out_*.
// The master is the host, the slave is the sequencer.
interface matmul_seq_ctrl_if #(
  parameter int DWIDTH = 16
);
  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DWIDTH-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the 3x3 matrix-multiply datapath: loads A then B, runs a fixed compute window, drains C.
// Latency: operand write one cycle after acceptance; one result per READ_LAT+2 cycles at best.
// Backpressure: in_ready only in IDLE/LOAD states; result held in RD_HOLD until out_ready.
module matmul_seq_ctrl #(
  parameter int DWIDTH         = 16,
  parameter int AWIDTH         = 4,
  parameter int NELEM          = 9,
  parameter int COMPUTE_CYCLES = 24,
  parameter int READ_LAT       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  matmul_seq_ctrl_if.slave     host,
  output logic                 busy,
  output logic                 done,
  output logic                 mm_we1,
  output logic                 mm_we2,
  output logic                 mm_start,
  output logic [AWIDTH-1:0]    mm_addr,
  output logic [DWIDTH-1:0]    mm_data,
  output logic [AWIDTH-1:0]    mm_res_addr,
  input  logic [DWIDTH-1:0]    mm_res_data
);

  localparam int CW = $clog2(COMPUTE_CYCLES + 1);
  localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(NELEM - 1);
  localparam logic [CW-1:0]     CMP_LAST = CW'(COMPUTE_CYCLES);
  localparam logic [LW-1:0]     LAT_LAST = LW'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_COMPUTE, S_RD_ISSUE, S_RD_WAIT, S_RD_HOLD, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   elem_cnt_q, elem_cnt_d;
  logic [AWIDTH-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]       cmp_cnt_q, cmp_cnt_d;
  logic [LW-1:0]       lat_cnt_q, lat_cnt_d;
  logic                we1_q, we1_d;
  logic                we2_q, we2_d;
  logic                start_q, start_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic                out_valid_q, out_valid_d;
  logic [DWIDTH-1:0]   out_data_q, out_data_d;
  logic                in_rdy;
  logic                accept;

  assign in_rdy        = (state_q == S_IDLE) || (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign accept        = host.in_valid && in_rdy;
  assign host.in_ready = in_rdy;
  assign host.out_valid = out_valid_q;
  assign host.out_data  = out_data_q;
  assign mm_we1      = we1_q;
  assign mm_we2      = we2_q;
  assign mm_start    = start_q;
  assign mm_addr     = addr_q;
  assign mm_data     = data_q;
  // The result address is the read counter itself; it stays stable through issue, wait and hold.
  assign mm_res_addr = rd_cnt_q;

  // Next-state, counter and registered-output logic for the job sequence.
  always_comb begin
    state_d     = state_q;
    elem_cnt_d  = elem_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    cmp_cnt_d   = cmp_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    we1_d       = 1'b0;
    we2_d       = 1'b0;
    start_d     = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy        = 1'b1;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) begin
          we1_d      = 1'b1;
          addr_d     = '0;
          data_d     = host.in_data;
          elem_cnt_d = AWIDTH'(1);
          state_d    = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (accept) begin
          we1_d  = 1'b1;
          addr_d = elem_cnt_q;
          data_d = host.in_data;
          if (elem_cnt_q == LAST_IDX) begin
            elem_cnt_d = '0;
            state_d    = S_LOAD_B;
          end else begin
            elem_cnt_d = elem_cnt_q + AWIDTH'(1);
          end
        end
      end
      S_LOAD_B: begin
        if (accept) begin
          we2_d  = 1'b1;
          addr_d = elem_cnt_q;
          data_d = host.in_data;
          if (elem_cnt_q == LAST_IDX) begin
            elem_cnt_d = '0;
            cmp_cnt_d  = '0;
            state_d    = S_COMPUTE;
          end else begin
            elem_cnt_d = elem_cnt_q + AWIDTH'(1);
          end
        end
      end
      S_COMPUTE: begin
        // First COMPUTE cycle carries the final B write, so start lags state entry by one.
        if (cmp_cnt_q == CMP_LAST) begin
          cmp_cnt_d = '0;
          rd_cnt_d  = '0;
          state_d   = S_RD_ISSUE;
        end else begin
          start_d   = 1'b1;
          cmp_cnt_d = cmp_cnt_q + CW'(1);
          if (cmp_cnt_q == '0) begin
            addr_d = '0;
          end
        end
      end
      S_RD_ISSUE: begin
        lat_cnt_d = '0;
        state_d   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          out_data_d  = mm_res_data;
          out_valid_d = 1'b1;
          state_d     = S_RD_HOLD;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      S_RD_HOLD: begin
        if (out_valid_q && host.out_ready) begin
          out_valid_d = 1'b0;
          if (rd_cnt_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            rd_cnt_d = rd_cnt_q + AWIDTH'(1);
            state_d  = S_RD_ISSUE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      elem_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      cmp_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      we1_q       <= 1'b0;
      we2_q       <= 1'b0;
      start_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_cnt_q  <= elem_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      cmp_cnt_q   <= cmp_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      we1_q       <= we1_d;
      we2_q       <= we2_d;
      start_q     <= start_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
